// File: rtl/spi_master_byte.sv
// spi_master_byte: SPI mode-0 master that frames valid/ready words under SSEL.
// Define SPI_LSB_FIRST_EN to shift LSB first on both MOSI and MISO.
module spi_master_byte #(
    parameter int CLK_DIV = 5,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              SCK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              SSEL
);
    localparam int BW = $clog2(DATA_W + 1);
    typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, TAIL, GAP} state_t;
    state_t state, state_n;
    logic [7:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [DATA_W-1:0] tx_sh, rx_sh, tx_nx, rx_nx;
    logic last, accept, phase_end, last_bit;
`ifdef SPI_LSB_FIRST_EN
    assign MOSI  = tx_sh[0];
    assign tx_nx = tx_sh >> 1;
    assign rx_nx = {MISO, rx_sh[DATA_W-1:1]};
`else
    assign MOSI  = tx_sh[DATA_W-1];
    assign tx_nx = tx_sh << 1;
    assign rx_nx = {rx_sh[DATA_W-2:0], MISO};
`endif
    assign busy = !SSEL || state == GAP;
    always_comb begin
        tx_ready  = !rst && (state == IDLE || state == WAIT);
        accept    = tx_valid && tx_ready;
        phase_end = div_cnt == 8'(CLK_DIV - 1);
        last_bit  = bit_cnt == BW'(DATA_W - 1);
        state_n   = state;
        case (state)
            IDLE, WAIT: state_n = accept ? LOW : state;
            LOW:        state_n = phase_end ? HIGH : LOW;
            HIGH:       state_n = !phase_end ? HIGH : !last_bit ? LOW : last ? TAIL : WAIT;
            TAIL:       state_n = phase_end ? GAP : TAIL;
            GAP:        state_n = phase_end ? IDLE : GAP;
            default:    state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            last     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            SCK      <= 1'b0;
            SSEL     <= 1'b1;
        end else begin
            state    <= state_n;
            div_cnt  <= state_n != state ? 8'd0 : div_cnt + 8'd1;
            rx_valid <= state == HIGH && phase_end && last_bit;
            SCK      <= state_n == HIGH;
            SSEL     <= state_n inside {IDLE, GAP};
            if (accept) begin
                tx_sh   <= tx_data;
                last    <= tx_last;
                bit_cnt <= '0;
            end
            if (state == LOW && phase_end)
                rx_sh <= rx_nx;
            // the last bit stays on MOSI through WAIT/TAIL
            if (state == HIGH && phase_end) begin
                bit_cnt <= bit_cnt + BW'(1);
                if (!last_bit)
                    tx_sh <= tx_nx;
                else
                    rx_data <= rx_sh;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_byte.sv
// tb_spi_master_byte: scoreboard bench for spi_master_byte (loopback, tied and slave-model MISO).
module tb_spi_master_byte;
    localparam int DIV = 5;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic tx_last = 1'b0, tx_valid = 1'b0, tx_ready;
    logic [7:0] rx_data;
    logic rx_valid, busy, SCK, MOSI, MISO, SSEL;
    int checks = 0, passed = 0, cyc = 0, rises = 0, ssel_rises = 0, rx_cnt = 0, rv_cyc = 0, ss_cyc = 0;
    int rise_q[$];
    logic mosi_q[$];
    logic [7:0] sb[$];
    logic [7:0] e_rx;
    logic [1:0] miso_mode = 2'd0;
    logic [7:0] sl_byte = 8'h00;
    int sl_idx = 0, dly = 0;
    logic sck_q = 1'b0, ssel_q = 1'b1, sl_sck = 1'b0;

    spi_master_byte #(.CLK_DIV(DIV), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SSEL(SSEL)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic bitk(input logic [7:0] d, input int k);
`ifdef SPI_LSB_FIRST_EN
        return d[k];
`else
        return d[7-k];
`endif
    endfunction

    assign MISO = miso_mode == 2'd0 ? MOSI : miso_mode == 2'd1 ? 1'b1 : bitk(sl_byte, sl_idx > 7 ? 7 : sl_idx);

    // slave model: first bit on SSEL fall, next bit 3 cycles after each SCK fall
    always @(negedge clk) begin
        if (SSEL !== 1'b0) begin
            sl_idx = 0;
            dly = 0;
        end else if (sl_sck && !SCK) dly = 3;
        else if (dly > 0) begin
            dly--;
            if (dly == 0) sl_idx++;
        end
        sl_sck = SCK;
    end

    always @(negedge clk) begin
        if (SCK && !sck_q) begin
            rises++;
            rise_q.push_back(cyc);
            mosi_q.push_back(MOSI);
        end
        if (SSEL && !ssel_q) begin
            ssel_rises++;
            ss_cyc = cyc;
        end
        if (rx_valid) begin
            rx_cnt++;
            rv_cyc = cyc;
            checks++;
            if (sb.size() == 0) $display("FAIL rx_unexpected: got rx_data=%h with no word pending", rx_data);
            else begin
                e_rx = sb.pop_front();
                if (rx_data !== e_rx) $display("FAIL rx_data: got %h required %h", rx_data, e_rx);
                else passed++;
            end
        end
        sck_q = SCK;
        ssel_q = SSEL;
    end

    task automatic send(input logic [7:0] d, input logic l, input logic push, input logic [7:0] exp, output int acc);
        tx_data = d;
        tx_last = l;
        tx_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 2000; i++) begin
            if (tx_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            checks++;
            $display("FAIL send_timeout: tx_ready=%b required 1", tx_ready);
            tx_valid = 1'b0;
            return;
        end
        if (push) sb.push_back(exp);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = ~d;
        tx_last = ~l;
    endtask

    task automatic wait_idle(output int t);
        t = -1;
        for (int i = 0; i < 3000; i++) begin
            if (tx_ready && SSEL && !busy) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) begin
            checks++;
            $display("FAIL idle_timeout: tx_ready=%b SSEL=%b busy=%b required 1 1 0", tx_ready, SSEL, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (SSEL !== 1'b1) $display("FAIL reset_ssel: got %b required 1", SSEL); else passed++;
        checks++; if (SCK !== 1'b0) $display("FAIL reset_sck: got %b required 0", SCK); else passed++;
        checks++; if (MOSI !== 1'b0) $display("FAIL reset_mosi: got %b required 0", MOSI); else passed++;
        checks++; if (tx_ready !== 1'b0) $display("FAIL reset_tx_ready: got %b required 0", tx_ready); else passed++;
        checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b required 0", rx_valid); else passed++;
        checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h required 00", rx_data); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) $display("FAIL post_reset_tx_ready: got %b required 1", tx_ready); else passed++;
    endtask

    task automatic test_single(input logic [7:0] d);
        int acc, tr;
        miso_mode = 2'd0;
        send(d, 1'b1, 1'b1, d, acc);
        rise_q.delete();
        mosi_q.delete();
        checks++; if ({SSEL, busy, SCK} !== 3'b010) $display("FAIL single_start: SSEL/busy/SCK got %b required 010", {SSEL, busy, SCK}); else passed++;
        wait_idle(tr);
        checks++; if (rise_q.size() != 8) $display("FAIL single_rise_count: got %0d required 8", rise_q.size()); else passed++;
        for (int k = 0; k < 8 && k < rise_q.size(); k++) begin
            checks++;
            if (rise_q[k] - acc != 1 + (2 * k + 1) * DIV) $display("FAIL single_rise%0d: offset %0d required %0d", k, rise_q[k] - acc, 1 + (2 * k + 1) * DIV);
            else passed++;
            checks++;
            if (mosi_q[k] !== bitk(d, k)) $display("FAIL single_mosi%0d: got %b required %b", k, mosi_q[k], bitk(d, k));
            else passed++;
        end
        checks++; if (rv_cyc - acc != 1 + 16 * DIV) $display("FAIL single_rx_valid_time: offset %0d required %0d", rv_cyc - acc, 1 + 16 * DIV); else passed++;
        checks++; if (ss_cyc - acc != 1 + 17 * DIV) $display("FAIL single_ssel_time: offset %0d required %0d", ss_cyc - acc, 1 + 17 * DIV); else passed++;
        checks++; if (tr - acc != 1 + 18 * DIV) $display("FAIL single_ready_time: offset %0d required %0d", tr - acc, 1 + 18 * DIV); else passed++;
    endtask

    task automatic test_back_to_back();
        int a, t, r0, s0, c0;
        miso_mode = 2'd0;
        r0 = rises; s0 = ssel_rises; c0 = rx_cnt;
        send(8'h3C, 1'b0, 1'b1, 8'h3C, a);
        send(8'hFF, 1'b0, 1'b1, 8'hFF, a);
        send(8'h00, 1'b1, 1'b1, 8'h00, a);
        wait_idle(t);
        checks++; if (rises - r0 != 24) $display("FAIL b2b_sck_pulses: got %0d required 24", rises - r0); else passed++;
        checks++; if (ssel_rises - s0 != 1) $display("FAIL b2b_ssel_releases: got %0d required 1", ssel_rises - s0); else passed++;
        checks++; if (rx_cnt - c0 != 3) $display("FAIL b2b_rx_strobes: got %0d required 3", rx_cnt - c0); else passed++;
    endtask

    task automatic test_stall();
        int a, t, bad, r0;
        logic got;
        miso_mode = 2'd0;
        send(8'h81, 1'b0, 1'b1, 8'h81, a);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (tx_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (got !== 1'b1) $display("FAIL stall_wait_entry: tx_ready got %b required 1", tx_ready); else passed++;
        bad = 0; r0 = rises;
        repeat (200) begin
            @(negedge clk);
            if (SSEL !== 1'b0 || SCK !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        checks++; if (bad != 0) $display("FAIL stall_hold: %0d bad cycles required 0", bad); else passed++;
        checks++; if (rises != r0) $display("FAIL stall_sck: %0d pulses required 0", rises - r0); else passed++;
        send(8'h7E, 1'b1, 1'b1, 8'h7E, a);
        wait_idle(t);
    endtask

    task automatic test_miso();
        int a, t;
        miso_mode = 2'd1;
        send(8'h00, 1'b1, 1'b1, 8'hFF, a);
        wait_idle(t);
        miso_mode = 2'd2;
        sl_byte = 8'h5A;
        send(8'h0F, 1'b1, 1'b1, 8'h5A, a);
        wait_idle(t);
        sl_byte = 8'h01;
        send(8'hF0, 1'b1, 1'b1, 8'h01, a);
        wait_idle(t);
        miso_mode = 2'd0;
    endtask

    task automatic test_reset_mid();
        int a, t, r0, c0;
        miso_mode = 2'd0;
        r0 = rises; c0 = rx_cnt;
        send(8'hFF, 1'b1, 1'b0, 8'h00, a);
        for (int i = 0; i < 200; i++) begin
            if (rises - r0 >= 3) break;
            @(negedge clk);
        end
        checks++; if (rises - r0 != 3) $display("FAIL mid_reach: got %0d rises required 3", rises - r0); else passed++;
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({SSEL, SCK, MOSI, rx_valid} !== 4'b1000) $display("FAIL mid_reset_outputs: SSEL/SCK/MOSI/rx_valid got %b required 1000", {SSEL, SCK, MOSI, rx_valid}); else passed++;
        rst = 1'b0;
        r0 = rises;
        repeat (120) @(negedge clk);
        checks++; if (rx_cnt != c0) $display("FAIL mid_no_strobe: got %0d strobes required 0", rx_cnt - c0); else passed++;
        checks++; if (rises != r0) $display("FAIL mid_no_sck: got %0d pulses required 0", rises - r0); else passed++;
        send(8'h96, 1'b1, 1'b1, 8'h96, a);
        wait_idle(t);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single(8'hA5);
        test_single(8'h01);
        test_back_to_back();
        test_stall();
        test_miso();
        test_reset_mid();
        repeat (5) @(negedge clk);
        checks++; if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d words pending required 0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
